// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter owner; prioritises and buffers redirects
//               across stalls, emits pipeline flush requests, latches HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pc_WEN,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    output logic [31:0] imemaddr,
    output logic        imemREN,
    output logic [31:0] pc_plus4,
    output logic [3:0]  flushes,
    output logic        pend_valid,
    output logic        halted
);

    localparam logic [1:0] c_CLS_SEQ = 2'd0;
    localparam logic [1:0] c_CLS_JMP = 2'd1;
    localparam logic [1:0] c_CLS_JR  = 2'd2;
    localparam logic [1:0] c_CLS_BR  = 2'd3;

    localparam logic [3:0] c_FLUSH_NONE = 4'b0000;
    localparam logic [3:0] c_FLUSH_ID   = 4'b0001;
    localparam logic [3:0] c_FLUSH_EX   = 4'b0011;

    logic [31:0] r_pc;
    logic [31:0] r_pend_tgt;
    logic [1:0]  r_pend_cls;
    logic        r_pend_valid;
    logic        r_halted;

    logic [1:0]  w_new_cls;
    logic [31:0] w_new_tgt;
    logic        w_new_wins;
    logic [1:0]  w_sel_cls;
    logic [31:0] w_sel_tgt;
    logic [31:0] w_pc_plus4;
    logic        w_advance;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Targets are word-aligned before they are used or buffered.
    always_comb begin
        w_new_cls = c_CLS_SEQ;
        w_new_tgt = w_pc_plus4;
        if (br_taken) begin
            w_new_cls = c_CLS_BR;
            w_new_tgt = {br_target[31:2], 2'b00};
        end else if (jr) begin
            w_new_cls = c_CLS_JR;
            w_new_tgt = {jr_target[31:2], 2'b00};
        end else if (jump) begin
            w_new_cls = c_CLS_JMP;
            w_new_tgt = {jump_target[31:2], 2'b00};
        end
    end

    assign w_new_wins = (w_new_cls != c_CLS_SEQ) &&
                        (!r_pend_valid || (w_new_cls >= r_pend_cls));

    always_comb begin
        w_sel_cls = c_CLS_SEQ;
        w_sel_tgt = w_pc_plus4;
        if (w_new_wins) begin
            w_sel_cls = w_new_cls;
            w_sel_tgt = w_new_tgt;
        end else if (r_pend_valid) begin
            w_sel_cls = r_pend_cls;
            w_sel_tgt = r_pend_tgt;
        end
    end

    // An incoming halt pre-empts the update, so no flush is raised with it.
    assign w_advance = pc_WEN && !r_halted && !halt && !RST;

    always_comb begin
        flushes = c_FLUSH_NONE;
        if (w_advance) begin
            case (w_sel_cls)
                c_CLS_BR:             flushes = c_FLUSH_EX;
                c_CLS_JR, c_CLS_JMP:  flushes = c_FLUSH_ID;
                default:              flushes = c_FLUSH_NONE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc         <= PC_INIT;
            r_pend_tgt   <= 32'd0;
            r_pend_cls   <= c_CLS_SEQ;
            r_pend_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else if (r_halted) begin
            r_pend_valid <= 1'b0;
        end else if (halt) begin
            r_halted     <= 1'b1;
            r_pend_valid <= 1'b0;
            r_pend_cls   <= c_CLS_SEQ;
        end else if (pc_WEN) begin
            r_pc         <= w_sel_tgt;
            r_pend_valid <= 1'b0;
            r_pend_cls   <= c_CLS_SEQ;
        end else if (w_new_wins) begin
            r_pend_tgt   <= w_new_tgt;
            r_pend_cls   <= w_new_cls;
            r_pend_valid <= 1'b1;
        end
    end

    assign imemaddr   = r_pc;
    assign imemREN    = !r_halted;
    assign pc_plus4   = w_pc_plus4;
    assign pend_valid = r_pend_valid;
    assign halted     = r_halted;

endmodule
`default_nettype wire
